// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions.
//   key_len_e   : key length selector (128/192/256/reserved)
//   RCON_TAB    : Rcon bytes for indices 1..10
//   rcon_count  : sequence length for a key length (10/8/7)
//   rcon_last   : final Rcon byte for a key length (start byte in reverse order)
//   rcon_lookup : guarded table read, returns 0 outside 1..10
package aes_pkg;

    typedef enum logic [1:0] {
        KL_128  = 2'd0,
        KL_192  = 2'd1,
        KL_256  = 2'd2,
        KL_RSVD = 2'd3
    } key_len_e;

    // Leftmost element is index 1.
    localparam logic [1:10][7:0] RCON_TAB = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [3:0] rcon_count(key_len_e kl);
        case (kl)
            KL_128:  return 4'd10;
            KL_192:  return 4'd8;
            KL_256:  return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] rcon_last(key_len_e kl);
        case (kl)
            KL_128:  return 8'h36;
            KL_192:  return 8'h80;
            KL_256:  return 8'h40;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rcon_lookup(logic [3:0] idx);
        if (idx >= 4'd1 && idx <= 4'd10) begin
            return RCON_TAB[idx];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/rcon_sched_if.sv
// Handshake bundle between the key-expansion controller / key-word datapath
// and rcon_sched.
//   master : drives start/key_len/reverse/abort/out_ready, observes the stream
//   slave  : the scheduler (drives out_valid/out_rcon/out_round/out_last/busy/err)
interface rcon_sched_if #(
    parameter int unsigned RCON_W = 32
);
    logic              start;
    logic [1:0]        key_len;
    logic              reverse;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [RCON_W-1:0] out_rcon;
    logic [3:0]        out_round;
    logic              out_last;
    logic              busy;
    logic              err;

    modport master (
        output start, key_len, reverse, abort, out_ready,
        input  out_valid, out_rcon, out_round, out_last, busy, err
    );

    modport slave (
        input  start, key_len, reverse, abort, out_ready,
        output out_valid, out_rcon, out_round, out_last, busy, err
    );
endinterface

// File: rtl/rcon_xtime.sv
// Combinational GF(2^8) multiply by x (inv=0) or by x^-1 (inv=1),
// AES polynomial 0x11b.
//   din  : input byte
//   inv  : 0 = forward xtime, 1 = inverse xtime
//   dout : result byte
module rcon_xtime (
    input  logic [7:0] din,
    input  logic       inv,
    output logic [7:0] dout
);
    logic [7:0] fwd;
    logic [8:0] inv_full;

    always_comb begin
        fwd      = {din[6:0], 1'b0} ^ (din[7] ? 8'h1b : 8'h00);
        // Adding the polynomial when b0 is set makes the value divisible by x.
        inv_full = {1'b0, din} ^ (din[0] ? 9'h11b : 9'h000);
        dout     = inv ? inv_full[8:1] : fwd;
    end
endmodule

// File: rtl/rcon_sched.sv
// AES round-constant scheduler: streams Rcon[1..N] (forward) or Rcon[N..1]
// (reverse) over a valid/ready interface, tagged with the round index.
// Optional macro RCON_TABLE_EN: read the byte from aes_pkg::RCON_TAB by round
// instead of stepping a byte register through rcon_xtime.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rcon_sched_if.slave (start/key_len/reverse/abort/out_ready in,
//           out_valid/out_rcon/out_round/out_last/busy/err out)
module rcon_sched
    import aes_pkg::*;
#(
    parameter int unsigned RCON_W    = 32,
    parameter int unsigned BYTE_LANE = 0
) (
    input logic         clk,
    input logic         rst_n,
    rcon_sched_if.slave bus
);
    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [0:0] state_q, state_d;
    logic       rev_q, rev_d;
    logic [3:0] count_q, count_d;
    logic [3:0] round_q, round_d;
    logic       last_q, last_d;
    logic       err_q, err_d;
    logic [7:0] byte_val;
    key_len_e   kl;

`ifndef RCON_TABLE_EN
    logic [7:0] byte_q, byte_d;
    logic [7:0] xt_out;

    rcon_xtime u_xtime (
        .din  (byte_q),
        .inv  (rev_q),
        .dout (xt_out)
    );

    assign byte_val = byte_q;
`else
    // Round 0 (idle) reads as 0, matching the cleared byte register build.
    assign byte_val = rcon_lookup(round_q);
`endif

    assign kl = key_len_e'(bus.key_len);

    always_comb begin
        state_d = state_q;
        rev_d   = rev_q;
        count_d = count_q;
        round_d = round_q;
        last_d  = last_q;
        err_d   = 1'b0;
`ifndef RCON_TABLE_EN
        byte_d  = byte_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    if (kl == KL_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StRun;
                        rev_d   = bus.reverse;
                        count_d = rcon_count(kl);
                        round_d = bus.reverse ? rcon_count(kl) : 4'd1;
                        last_d  = 1'b0;  // every mode has N >= 7
`ifndef RCON_TABLE_EN
                        byte_d  = bus.reverse ? rcon_last(kl) : 8'h01;
`endif
                    end
                end
            end
            default: begin
                if (bus.abort || (bus.out_ready && last_q)) begin
                    state_d = StIdle;
                    round_d = 4'd0;
                    last_d  = 1'b0;
`ifndef RCON_TABLE_EN
                    byte_d  = 8'h00;
`endif
                end else if (bus.out_ready) begin
                    round_d = rev_q ? round_q - 4'd1 : round_q + 4'd1;
                    last_d  = rev_q ? (round_q == 4'd2) : (round_q + 4'd1 == count_q);
`ifndef RCON_TABLE_EN
                    byte_d  = xt_out;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rev_q   <= 1'b0;
            count_q <= 4'd0;
            round_q <= 4'd0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
`ifndef RCON_TABLE_EN
            byte_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            rev_q   <= rev_d;
            count_q <= count_d;
            round_q <= round_d;
            last_q  <= last_d;
            err_q   <= err_d;
`ifndef RCON_TABLE_EN
            byte_q  <= byte_d;
`endif
        end
    end

    logic [RCON_W-1:0] word;

    always_comb begin
        word                    = '0;
        word[8*BYTE_LANE +: 8]  = byte_val;
    end

    assign bus.out_valid = (state_q == StRun);
    assign bus.busy      = (state_q == StRun);
    assign bus.out_rcon  = word;
    assign bus.out_round = round_q;
    assign bus.out_last  = last_q;
    assign bus.err       = err_q;
endmodule
